// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: load/store codes,
// controller state encodings and a helper that maps an instruction code to
// its access width.
package mem_access_ctrl_pkg;

   // Register-write load codes shared with the decode and write-back stages
   localparam logic [2:0] LB         = 3'd0;
   localparam logic [2:0] LH         = 3'd1;
   localparam logic [2:0] LW         = 3'd2;
   localparam logic [2:0] LBU        = 3'd4;
   localparam logic [2:0] LHU        = 3'd5;
   localparam logic [2:0] NOREGWRITE = 3'd7;

   // Store codes
   localparam logic [1:0] SB = 2'd0;
   localparam logic [1:0] SH = 2'd1;
   localparam logic [1:0] SW = 2'd2;

   // Controller state encodings
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   // Width of a memory access; SIZE_NONE marks codes that never touch memory
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_NONE = 2'd3
   } access_size_t;

   // Access width of a load code; NOREGWRITE and unused codes have no width
   function automatic access_size_t load_size(input logic [2:0] load_type);
      access_size_t size;
      case (load_type)
         LB, LBU: size = SIZE_BYTE;
         LH, LHU: size = SIZE_HALF;
         LW:      size = SIZE_WORD;
         default: size = SIZE_NONE;
      endcase
      return size;
   endfunction

   // Access width of a store code; the unused fourth code has no width
   function automatic access_size_t store_size(input logic [1:0] store_type);
      access_size_t size;
      case (store_type)
         SB:      size = SIZE_BYTE;
         SH:      size = SIZE_HALF;
         SW:      size = SIZE_WORD;
         default: size = SIZE_NONE;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Byte-lane logic for one load/store: decides whether the offset is legal
// for the access width and produces byte enables and lane-shifted store
// data. Loads produce no enables and no data. Codes without an access width
// are reported as illegal so they are rejected without touching memory.
module mem_byte_lane (
   input  logic [1:0]  offset,
   input  logic        mem_write,
   input  logic [2:0]  load_type,
   input  logic [1:0]  store_type,
   input  logic [31:0] store_data,
   output logic        legal,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata
);
   import mem_access_ctrl_pkg::*;

   access_size_t size;

   // Classify the access and build enables/data for the addressed lanes
   always_comb begin
      size    = mem_write ? store_size(store_type) : load_size(load_type);
      legal   = 1'b0;
      byte_en = 4'b0000;
      wdata   = 32'h0000_0000;
      case (size)
         SIZE_BYTE: begin
            legal = 1'b1;
            if (mem_write) begin
               byte_en = 4'b0001 << offset;
               wdata   = store_data << {offset, 3'b000};
            end
         end
         SIZE_HALF: begin
            legal = (offset != 2'd3);
            if (mem_write) begin
               byte_en = 4'b0011 << offset;
               wdata   = store_data << {offset, 3'b000};
            end
         end
         SIZE_WORD: begin
            legal = (offset == 2'd0);
            if (mem_write) begin
               byte_en = 4'b1111;
               wdata   = store_data;
            end
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller. Accepts one load/store at a time from
// the pipeline, drives it onto a req/ack data memory, stalls the pipeline
// until it completes, and hands the returned word plus the low address bits
// to the load-extension unit. A timeout turns a silent memory into a bus
// error instead of a hung pipeline.
module mem_access_ctrl #(
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [2:0]  LoadType,
   input  logic [1:0]  StoreType,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic        DmReq,
   output logic [29:0] DmAddr,
   output logic [3:0]  DmWe,
   output logic [31:0] DmWdata,
   input  logic        DmAck,
   input  logic [31:0] DmRdata,
   output logic        StallM,
   output logic [31:0] LoadWord,
   output logic [1:0]  LoadedBytesSelect,
   output logic        LoadValid,
   output logic        MisalignFault,
   output logic        BusError
);
   import mem_access_ctrl_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   logic        lane_legal;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dm_req_q, dm_req_d;
   logic [29:0]      dm_addr_q, dm_addr_d;
   logic [3:0]       dm_we_q, dm_we_d;
   logic [31:0]      dm_wdata_q, dm_wdata_d;
   logic [31:0]      load_word_q, load_word_d;
   logic [1:0]       lbs_q, lbs_d;
   logic [1:0]       pend_off_q, pend_off_d;
   logic             pend_load_q, pend_load_d;
   logic             load_valid_q, load_valid_d;
   logic             misalign_q, misalign_d;
   logic             bus_err_q, bus_err_d;
   logic             stall;

   mem_byte_lane u_lane (
      .offset     (Addr[1:0]),
      .mem_write  (MemWrite),
      .load_type  (LoadType),
      .store_type (StoreType),
      .store_data (StoreData),
      .legal      (lane_legal),
      .byte_en    (lane_be),
      .wdata      (lane_wdata)
   );

   // Next-state, request latching, timeout counting and completion pulses
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dm_req_d     = dm_req_q;
      dm_addr_d    = dm_addr_q;
      dm_we_d      = dm_we_q;
      dm_wdata_d   = dm_wdata_q;
      load_word_d  = load_word_q;
      lbs_d        = lbs_q;
      pend_off_d   = pend_off_q;
      pend_load_d  = pend_load_q;
      load_valid_d = 1'b0;
      misalign_d   = 1'b0;
      bus_err_d    = 1'b0;
      stall        = 1'b0;
      case (state_q)
         IDLE: begin
            stall = MemReq;
            if (MemReq) begin
               if (lane_legal) begin
                  dm_req_d    = 1'b1;
                  dm_addr_d   = Addr[31:2];
                  dm_we_d     = lane_be;
                  dm_wdata_d  = lane_wdata;
                  pend_off_d  = Addr[1:0];
                  pend_load_d = ~MemWrite;
                  cnt_d       = '0;
                  state_d     = ACCESS;
               end else begin
                  misalign_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (DmAck) begin
               dm_req_d = 1'b0;
               dm_we_d  = 4'b0000;
               state_d  = DONE;
               if (pend_load_q) begin
                  load_word_d  = DmRdata;
                  lbs_d        = pend_off_q;
                  load_valid_d = 1'b1;
               end
            end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
               dm_req_d    = 1'b0;
               dm_we_d     = 4'b0000;
               bus_err_d   = 1'b1;
               load_word_d = 32'h0000_0000;
               state_d     = DONE;
            end else if (TIMEOUT_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            dm_req_d = 1'b0;
            dm_we_d  = 4'b0000;
         end
      endcase
   end

   // Controller registers; reset abandons any access in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dm_req_q     <= 1'b0;
         dm_addr_q    <= 30'h0;
         dm_we_q      <= 4'b0000;
         dm_wdata_q   <= 32'h0000_0000;
         load_word_q  <= 32'h0000_0000;
         lbs_q        <= 2'b00;
         pend_off_q   <= 2'b00;
         pend_load_q  <= 1'b0;
         load_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dm_req_q     <= dm_req_d;
         dm_addr_q    <= dm_addr_d;
         dm_we_q      <= dm_we_d;
         dm_wdata_q   <= dm_wdata_d;
         load_word_q  <= load_word_d;
         lbs_q        <= lbs_d;
         pend_off_q   <= pend_off_d;
         pend_load_q  <= pend_load_d;
         load_valid_q <= load_valid_d;
         misalign_q   <= misalign_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign DmReq             = dm_req_q;
   assign DmAddr            = dm_addr_q;
   assign DmWe              = dm_we_q;
   assign DmWdata           = dm_wdata_q;
   assign StallM            = stall;
   assign LoadWord          = load_word_q;
   assign LoadedBytesSelect = lbs_q;
   assign LoadValid         = load_valid_q;
   assign MisalignFault     = misalign_q;
   assign BusError          = bus_err_q;

endmodule
